cube_edge_scheduler: RTL and testbench
======================================

# cube_edge_scheduler

Sequencer that time-shares one external line engine across the six slanted edges of the isometric cube (06, 12, 50, 64, 23, 45).
- On each row request it derives the cube vertices from the current offsets and the geometry parameters.
- For every edge whose vertical span covers the requested row, it issues one engine job and collects the returned x-intersection.
- It publishes all six x-positions atomically to the face-fill logic.
- It sits between the pixel-row timing and the shared line engine, replacing one engine instance per edge.

## Interface
Parameters:
- XLENGTH, 11'd120, horizontal edge length
- XDIAG, 11'd50, diagonal x step
- YDIAG, 10'd90, diagonal y step
- TIMEOUT, 8'd64, maximum cycles spent in WAIT per job

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low
- row_start  in  1  one-cycle request to compute edge positions for row_y
- row_y  in  10  target row, sampled with row_start
- x_offset  in  11  cube anchor x, sampled with row_start
- y_offset  in  10  cube anchor y, sampled with row_start
- busy  out  1  sequence in progress
- row_done  out  1  one-cycle pulse; x_* outputs updated in the same cycle
- err  out  1  sticky; at least one job timed out since the last accepted row_start
- eng_start  out  1  one-cycle job start
- eng_x0, eng_x1  out  11  edge endpoints (x)
- eng_y0, eng_y1  out  10  edge endpoints (y), with y0 ≤ y1
- eng_ytgt  out  10  row to intersect
- eng_done  in  1  job complete
- eng_x  in  11  intersection x, valid while eng_done = 1
- x_06, x_12, x_50, x_64, x_23, x_45  out  11  committed edge positions

## Operation
- Vertices (xo = x_offset, yo = y_offset):
  - P0 = (xo, yo)
  - P1 = (xo+XLENGTH, yo)
  - P2 = (xo+XLENGTH+XDIAG, yo+YDIAG)
  - P3 = (xo+XLENGTH, yo+2·YDIAG)
  - P4 = (xo, yo+2·YDIAG)
  - P5 = (xo−XDIAG, yo+YDIAG)
  - P6 = (xo+XDIAG, yo+YDIAG)
- Arithmetic is unsigned and wraps: x modulo 2^11, y modulo 2^10. Range comparisons use the wrapped values.
- Edges, in fixed issue order 0..5:
  - 06 = P0→P6
  - 12 = P1→P2
  - 50 = P0→P5
  - 64 = P6→P4
  - 23 = P2→P3
  - 45 = P5→P4
- An edge is in range when y0 ≤ row_y ≤ y1 (inclusive at both ends).
- FSM states: IDLE, LOAD, ISSUE, WAIT, DONE.
  - IDLE: row_start = 1 latches row_y, x_offset and y_offset; clears err; next state is LOAD. row_start in any other state is ignored.
  - LOAD: compute and register all vertices; edge index = 0; next state is ISSUE.
  - ISSUE, edge in range: drive eng_* for that edge, pulse eng_start, clear the wait counter, go to WAIT.
  - ISSUE, edge out of range: write 0 to that edge's shadow register. Then advance: index < 5 → ISSUE with the next index; index = 5 → DONE.
  - WAIT: eng_done = 1 writes eng_x to the shadow register, then advances as above.
  - WAIT timeout: when the counter reaches TIMEOUT with no eng_done, write 11'h7FF to the shadow register, set err, then advance.
  - WAIT, both events in the same cycle: eng_done wins and no error is recorded.
  - DONE: copy all six shadow registers to x_*, pulse row_done, return to IDLE.
- eng_x0/y0/x1/y1/ytgt stay stable from ISSUE until WAIT exits.
- eng_done outside WAIT is ignored.
- Reset at any point:
  - FSM returns to IDLE.
  - Forced to 0: busy, row_done, err, eng_start, all eng_* outputs, all x_*, all shadow registers.
  - The aborted sequence never commits.

## Timing
- Cycle 0 is the edge that samples row_start. LOAD occupies cycle 1; the first ISSUE occupies cycle 2.
- busy is 1 from cycle 1 through the DONE cycle inclusive; 0 otherwise.
- Let L be the engine latency: eng_done arrives L ≥ 1 cycles after eng_start.
- Cost per edge:
  - issued: L+1 cycles
  - skipped: 1 cycle
  - timed out: TIMEOUT+1 cycles
- DONE cycle = 2 + Σ(edge costs). row_done is high only in that cycle.
- x_* change only on the DONE cycle and hold their values between sequences.
- A new row_start is accepted on the cycle after DONE, since the FSM is then back in IDLE.

## Test plan
Common setup: xo = 400, yo = 200, engine model does exact linear interpolation with L = 3. Resulting vertices: P5 = (350,290), P6 = (450,290), P2 = (570,290), P4 = (400,380).
- row_y = 200 → x_06 = 400, x_12 = 520, x_50 = 400, lower three edges = 0, row_done at cycle 17, err = 0.
- row_y = 290 (boundary of both halves) → 450, 570, 350, 450, 570, 350, row_done at cycle 26.
- row_y = 100 (all edges out of range) → no eng_start, all x_* = 0, row_done at cycle 8.
- Engine never asserts eng_done, TIMEOUT = 16, row_y = 250 → three upper edges = 11'h7FF, lower edges = 0, err = 1. err clears on the next accepted row_start.
- Reset pulsed low during the second WAIT → next cycle: busy = 0, x_* = 0, no row_done. A following row_start completes normally.
- xo = 20, row_y = 290, extra row_start pulses while busy → eng_x1 for edge 50 = 2018 (wrapped), extra requests ignored, exactly one row_done.

Source files
------------

// File: rtl/cube_edge_scheduler.sv
// cube_edge_scheduler: shares one line engine across the six slanted cube edges per pixel row
module cube_edge_scheduler #(
  parameter logic [10:0] XLENGTH = 11'd120,
  parameter logic [10:0] XDIAG = 11'd50,
  parameter logic [9:0] YDIAG = 10'd90,
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic clk,
  input  logic reset,
  input  logic row_start,
  input  logic [9:0] row_y,
  input  logic [10:0] x_offset,
  input  logic [9:0] y_offset,
  output logic busy,
  output logic row_done,
  output logic err,
  output logic eng_start,
  output logic [10:0] eng_x0,
  output logic [10:0] eng_x1,
  output logic [9:0] eng_y0,
  output logic [9:0] eng_y1,
  output logic [9:0] eng_ytgt,
  input  logic eng_done,
  input  logic [10:0] eng_x,
  output logic [10:0] x_06,
  output logic [10:0] x_12,
  output logic [10:0] x_50,
  output logic [10:0] x_64,
  output logic [10:0] x_23,
  output logic [10:0] x_45
);
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [9:0] ry, yo, vy2, vy3;
  logic [10:0] xo, vx1, vx2, vx5, vx6, wv;
  logic [2:0] idx;
  logic [7:0] cnt;
  logic [10:0] ex0 [6], ex1 [6], sh [6], xq [6];
  logic [9:0] ey0 [6], ey1 [6];
  logic in_range, tmo, wr;
  assign vx1 = xo + XLENGTH;
  assign vx2 = vx1 + XDIAG;
  assign vx5 = xo - XDIAG;
  assign vx6 = xo + XDIAG;
  assign vy2 = yo + YDIAG;
  assign vy3 = vy2 + YDIAG;
  assign in_range = ey0[idx] <= ry && ry <= ey1[idx];
  assign tmo = cnt == TIMEOUT - 8'd1;
  assign wr = (state == ISSUE && !in_range) || (state == WAIT && (eng_done || tmo));
  assign wv = state == WAIT ? (eng_done ? eng_x : 11'h7FF) : 11'd0;
  assign busy = state != IDLE;
  assign row_done = state == DONE;
  assign eng_start = state == ISSUE && in_range;
  assign eng_x0 = ex0[idx];
  assign eng_x1 = ex1[idx];
  assign eng_y0 = ey0[idx];
  assign eng_y1 = ey1[idx];
  assign eng_ytgt = ry;
  // the final shadow values are visible in the DONE cycle itself, then held in xq
  assign x_06 = row_done ? sh[0] : xq[0];
  assign x_12 = row_done ? sh[1] : xq[1];
  assign x_50 = row_done ? sh[2] : xq[2];
  assign x_64 = row_done ? sh[3] : xq[3];
  assign x_23 = row_done ? sh[4] : xq[4];
  assign x_45 = row_done ? sh[5] : xq[5];
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = row_start ? LOAD : IDLE;
    else if (state == LOAD) state_n = ISSUE;
    else if (state == ISSUE && in_range) state_n = WAIT;
    else if (wr) state_n = idx == 3'd5 ? DONE : ISSUE;
    else if (state == DONE) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      ry <= '0;
      xo <= '0;
      yo <= '0;
      err <= 1'b0;
      idx <= '0;
      cnt <= '0;
      ex0 <= '{default: '0};
      ex1 <= '{default: '0};
      ey0 <= '{default: '0};
      ey1 <= '{default: '0};
      sh <= '{default: '0};
      xq <= '{default: '0};
    end else begin
      if (state == IDLE && row_start) begin
        ry <= row_y;
        xo <= x_offset;
        yo <= y_offset;
        err <= 1'b0;
      end
      if (state == LOAD) begin
        idx <= '0;
        ex0 <= '{xo, vx1, xo, vx6, vx2, vx5};
        ex1 <= '{vx6, vx2, vx5, xo, vx1, xo};
        ey0 <= '{yo, yo, yo, vy2, vy2, vy2};
        ey1 <= '{vy2, vy2, vy2, vy3, vy3, vy3};
      end
      cnt <= state == ISSUE ? 8'd0 : state == WAIT ? cnt + 8'd1 : cnt;
      if (wr) begin
        sh[idx] <= wv;
        if (idx != 3'd5) idx <= idx + 3'd1;
      end
      if (state == WAIT && tmo && !eng_done) err <= 1'b1;
      if (state == DONE) xq <= sh;
    end
  end
endmodule

// File: tb/tb_cube_edge_scheduler.sv
// tb_cube_edge_scheduler: directed checks of the edge scheduler against an interpolating engine model
module tb_cube_edge_scheduler;
  logic clk = 0, reset = 0, row_start = 0, eng_done = 0, eng_en = 1;
  logic [9:0] row_y = 0, y_offset = 0;
  logic [10:0] x_offset = 0, eng_x = 0;
  logic busy, row_done, err, eng_start;
  logic [10:0] eng_x0, eng_x1, x_06, x_12, x_50, x_64, x_23, x_45;
  logic [9:0] eng_y0, eng_y1, eng_ytgt;
  logic [7:0] ecnt = 0;
  int errors = 0, checks = 0;
  int cyc, starts, extra;
  logic [10:0] x1_3rd;

  cube_edge_scheduler #(.TIMEOUT(8'd16)) dut (
    .clk(clk), .reset(reset), .row_start(row_start), .row_y(row_y),
    .x_offset(x_offset), .y_offset(y_offset), .busy(busy), .row_done(row_done),
    .err(err), .eng_start(eng_start), .eng_x0(eng_x0), .eng_x1(eng_x1),
    .eng_y0(eng_y0), .eng_y1(eng_y1), .eng_ytgt(eng_ytgt), .eng_done(eng_done),
    .eng_x(eng_x), .x_06(x_06), .x_12(x_12), .x_50(x_50), .x_64(x_64),
    .x_23(x_23), .x_45(x_45)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] interp(input logic [10:0] a, b, input logic [9:0] ya, yb, yt);
    logic [10:0] dx;
    int d;
    dx = b - a;
    d = $signed(dx);
    if (ya == yb) return a;
    return 11'(int'(a) + d * (int'(yt) - int'(ya)) / (int'(yb) - int'(ya)));
  endfunction

  // engine with latency 3: eng_done is high in the third cycle after eng_start
  always @(posedge clk) begin
    eng_done <= 1'b0;
    if (eng_start) begin
      ecnt <= 8'd2;
      eng_x <= interp(eng_x0, eng_x1, eng_y0, eng_y1, eng_ytgt);
    end else if (ecnt != 0) begin
      ecnt <= ecnt - 8'd1;
      if (ecnt == 8'd1 && eng_en) eng_done <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_x(input string tag, input logic [10:0] e0, e1, e2, e3, e4, e5);
    chk({tag, ".x_06"}, x_06, e0);
    chk({tag, ".x_12"}, x_12, e1);
    chk({tag, ".x_50"}, x_50, e2);
    chk({tag, ".x_64"}, x_64, e3);
    chk({tag, ".x_23"}, x_23, e4);
    chk({tag, ".x_45"}, x_45, e5);
  endtask

  task automatic run(input logic [9:0] y, input logic [10:0] xoff, input logic [9:0] yoff, input bit spam);
    @(negedge clk);
    row_y = y;
    x_offset = xoff;
    y_offset = yoff;
    row_start = 1;
    @(posedge clk);
    @(negedge clk);
    row_start = 0;
    cyc = 1;
    starts = 0;
    x1_3rd = 0;
    chk("busy_c1", busy, 1);
    while (!row_done && cyc < 300) begin
      if (eng_start) begin
        starts++;
        if (starts == 3) x1_3rd = eng_x1;
      end
      row_start = spam && (cyc % 5 == 0);
      row_y = 10'd100;
      @(negedge clk);
      cyc++;
    end
    row_start = 0;
    chk("row_done_seen", row_done, 1);
  endtask

  task automatic idle_watch(input int n);
    extra = 0;
    repeat (n) begin
      @(negedge clk);
      if (row_done || busy) extra++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.row_done", row_done, 0);
    chk("rst.err", err, 0);
    chk("rst.eng_start", eng_start, 0);
    chk("rst.eng_x0", eng_x0, 0);
    chk_x("rst", 0, 0, 0, 0, 0, 0);
    reset = 1;

    run(10'd200, 11'd400, 10'd200, 0);
    chk("r200.cycle", cyc, 17);
    chk("r200.starts", starts, 3);
    chk("r200.err", err, 0);
    chk_x("r200", 400, 520, 400, 0, 0, 0);
    @(negedge clk);
    chk("r200.pulse", row_done, 0);
    chk("r200.idle", busy, 0);

    run(10'd290, 11'd400, 10'd200, 0);
    chk("r290.cycle", cyc, 26);
    chk("r290.starts", starts, 6);
    chk_x("r290", 450, 570, 350, 450, 570, 350);
    idle_watch(4);
    chk("r290.hold_idle", extra, 0);
    chk_x("r290.hold", 450, 570, 350, 450, 570, 350);

    run(10'd100, 11'd400, 10'd200, 0);
    chk("r100.cycle", cyc, 8);
    chk("r100.starts", starts, 0);
    chk_x("r100", 0, 0, 0, 0, 0, 0);

    eng_en = 0;
    run(10'd250, 11'd400, 10'd200, 0);
    chk("tmo.cycle", cyc, 56);
    chk("tmo.err", err, 1);
    chk_x("tmo", 11'h7FF, 11'h7FF, 11'h7FF, 0, 0, 0);
    idle_watch(3);
    chk("tmo.err_sticky", err, 1);
    eng_en = 1;
    run(10'd200, 11'd400, 10'd200, 0);
    chk("clr.err", err, 0);
    chk_x("clr", 400, 520, 400, 0, 0, 0);

    @(negedge clk);
    row_y = 10'd290;
    x_offset = 11'd400;
    y_offset = 10'd200;
    row_start = 1;
    @(negedge clk);
    row_start = 0;
    starts = 0;
    cyc = 0;
    while (starts < 2 && cyc < 100) begin
      if (eng_start) starts++;
      if (starts < 2) @(negedge clk);
      cyc++;
    end
    chk("rst2.second_issue", starts, 2);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
    chk("rst2.busy", busy, 0);
    chk("rst2.row_done", row_done, 0);
    chk("rst2.eng_start", eng_start, 0);
    chk_x("rst2", 0, 0, 0, 0, 0, 0);
    idle_watch(8);
    chk("rst2.no_commit", extra, 0);
    run(10'd290, 11'd400, 10'd200, 0);
    chk("rst2.rerun_cycle", cyc, 26);
    chk_x("rst2.rerun", 450, 570, 350, 450, 570, 350);

    run(10'd290, 11'd20, 10'd200, 1);
    chk("wrap.cycle", cyc, 26);
    chk("wrap.eng_x1_50", x1_3rd, 2018);
    chk_x("wrap", 70, 190, 2018, 70, 190, 2018);
    idle_watch(30);
    chk("wrap.single_done", extra, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
